// File: rtl/gpio_pkg.sv
// Shared types for the GPIO port bank: register selects, edge modes and the
// per-bit edge qualifier used by the input synchronisers.
package gpio_pkg;

   typedef enum logic [1:0] {
      SEL_OUT  = 2'd0,
      SEL_OE   = 2'd1,
      SEL_IN   = 2'd2,
      SEL_PEND = 2'd3
   } sel_e;

   typedef enum logic [1:0] {
      RISE = 2'd0,
      FALL = 2'd1,
      BOTH = 2'd2
   } edge_e;

   function automatic logic edge_hit(edge_e mode, logic cur, logic prv);
      case (mode)
         RISE:    return cur & ~prv;
         FALL:    return ~cur & prv;
         default: return cur ^ prv;
      endcase
   endfunction

endpackage

// File: rtl/gpio_port_bank_if.sv
// Register request/response channel of the GPIO port bank; one outstanding
// request, valid/ready on both directions.
interface gpio_port_bank_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8
);
   import gpio_pkg::*;

   localparam int CHW = $clog2(NUM_CH) + 1;

   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [CHW-1:0]   req_ch;
   sel_e             req_sel;
   logic [WIDTH-1:0] req_wdata;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_rdata;
   logic             rsp_err;

   modport master (
      output req_valid, req_write, req_ch, req_sel, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_ch, req_sel, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/gpio_sync.sv
// Two-flop input synchroniser for one channel plus a history register that
// turns the synchronised value into a single-cycle edge pulse.
module gpio_sync
   import gpio_pkg::*;
#(
   parameter int    WIDTH     = 8,
   parameter edge_e EDGE_MODE = RISE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sync_q,
   output logic [WIDTH-1:0] edge_q
);

   logic [WIDTH-1:0] s1, s2, prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
      end
   end

   always_comb begin
      edge_q = '0;
      for (int i = 0; i < WIDTH; i++)
         edge_q[i] = edge_hit(EDGE_MODE, s2[i], prev[i]);
   end

   assign sync_q = s2;

endmodule

// File: rtl/gpio_port_bank.sv
// Bank of NUM_CH bidirectional WIDTH-bit ports: output/enable registers drive
// the pads, synchronised inputs feed sticky edge-pending bits and one irq.
module gpio_port_bank
   import gpio_pkg::*;
#(
   parameter int               NUM_CH    = 4,
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RST_OUT   = '0,
   parameter logic [WIDTH-1:0] RST_OE    = '0,
   parameter edge_e            EDGE_MODE = RISE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   inout  wire [NUM_CH*WIDTH-1:0]  pad,
   gpio_port_bank_if.slave         bus,
   output logic                    irq
);

   logic [NUM_CH-1:0][WIDTH-1:0] out_q, oe_q, pend_q, pend_nxt;
   logic [NUM_CH-1:0][WIDTH-1:0] sync_v, edge_v;
   logic [NUM_CH-1:0]            wr_hit;

   logic             rsp_valid_q, rsp_err_q;
   logic [WIDTH-1:0] rsp_rdata_q;
   logic             accept, ch_ok, req_err;
   logic [WIDTH-1:0] rd_mux, rdata_nxt;

   // Pads are driven straight from the registers so reset releases them at once.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
         assign pad[c*WIDTH+b] = oe_q[c][b] ? out_q[c][b] : 1'bz;
      end

      gpio_sync #(
         .WIDTH     (WIDTH),
         .EDGE_MODE (EDGE_MODE)
      ) u_sync (
         .clk    (clk),
         .rst_n  (rst_n),
         .din    (pad[c*WIDTH +: WIDTH]),
         .sync_q (sync_v[c]),
         .edge_q (edge_v[c])
      );
   end

   assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   assign accept  = bus.req_valid && bus.req_ready;
   assign ch_ok   = int'(bus.req_ch) < NUM_CH;
   assign req_err = !ch_ok || (bus.req_write && bus.req_sel == SEL_IN);

   always_comb begin
      rd_mux = '0;
      wr_hit = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (int'(bus.req_ch) == c) begin
            case (bus.req_sel)
               SEL_OUT:  rd_mux = out_q[c];
               SEL_OE:   rd_mux = oe_q[c];
               SEL_IN:   rd_mux = sync_v[c];
               default:  rd_mux = pend_q[c];
            endcase
            wr_hit[c] = accept && bus.req_write && !req_err;
         end
      end
      rdata_nxt = (req_err || bus.req_write) ? '0 : rd_mux;
   end

   // New edges are OR'd in after the W1C mask, so a coincident set wins.
   always_comb begin
      pend_nxt = pend_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (wr_hit[c] && bus.req_sel == SEL_PEND)
            pend_nxt[c] = pend_q[c] & ~bus.req_wdata;
         pend_nxt[c] = pend_nxt[c] | edge_v[c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= {NUM_CH{RST_OUT}};
         oe_q        <= {NUM_CH{RST_OE}};
         pend_q      <= '0;
         irq         <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_hit[c] && bus.req_sel == SEL_OUT) out_q[c] <= bus.req_wdata;
            if (wr_hit[c] && bus.req_sel == SEL_OE)  oe_q[c]  <= bus.req_wdata;
         end
         pend_q <= pend_nxt;
         irq    <= |pend_q;
         if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_nxt;
            rsp_err_q   <= req_err;
         end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gpio_port_bank.sv
// Directed bench for gpio_port_bank: requests push expected responses into a
// queue, a negedge monitor pops and compares each consumed response.
module tb_gpio_port_bank;
   import gpio_pkg::*;

   localparam int NUM_CH = 4;
   localparam int WIDTH  = 8;
   localparam int PW     = NUM_CH * WIDTH;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic irq;
   logic [PW-1:0] tb_drv;
   logic [PW-1:0] tb_en;
   wire  [PW-1:0] pad;

   always #5 clk = ~clk;

   for (genvar i = 0; i < PW; i++) begin : g_drv
      assign pad[i] = tb_en[i] ? tb_drv[i] : 1'bz;
   end

   gpio_port_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

   gpio_port_bank #(
      .NUM_CH    (NUM_CH),
      .WIDTH     (WIDTH),
      .RST_OUT   (8'hA5),
      .RST_OE    (8'h0F),
      .EDGE_MODE (RISE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pad   (pad),
      .bus   (bus),
      .irq   (irq)
   );

   typedef struct {
      logic [WIDTH-1:0] rdata;
      logic             err;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_unexpected: got response %0h, expected none", bus.rsp_rdata);
         end else begin
            mon_e = q.pop_front();
            check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
            check("rsp_err", bus.rsp_err, mon_e.err);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents one request, waits for acceptance and checks 1-cycle response latency.
   task automatic issue(input logic wr, input int ch, input sel_e sel,
                        input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] er, input logic ee);
      logic ok;
      bus.req_write = wr;
      bus.req_ch    = 3'(ch);
      bus.req_sel   = sel;
      bus.req_wdata = wd;
      bus.req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.req_ready) ok = 1'b1;
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_accept_timeout: got req_ready=0, expected 1 within 20 cycles");
         bus.req_valid = 1'b0;
         return;
      end
      q.push_back('{er, ee});
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("rsp_latency", bus.rsp_valid, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1);
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_ch    = '0;
      bus.req_sel   = SEL_OUT;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;
      tb_drv = '0;
      tb_en  = 32'hF0F0_F0F0;
      #1 rst_n = 1'b0;
      tick(2);

      // reset state
      check("rst_pad_ch0_lo", pad[3:0], 4'h5);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_err", bus.rsp_err, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_irq", irq, 0);
      check("rst_req_ready", bus.req_ready, 1);
      rst_n = 1'b1;

      // driven low-nibble bits 0 and 2 rise out of reset on every channel
      tick(6);
      check("irq_after_reset", irq, 1);
      issue(0, 0, SEL_PEND, 8'h00, 8'h05, 0);
      issue(0, 3, SEL_PEND, 8'h00, 8'h05, 0);

      // upper nibble of ch0 is not driven by the bank, so the bench value shows through
      tb_drv[7:4] = 4'h3;
      tick(4);
      issue(0, 0, SEL_IN,  8'h00, 8'h35, 0);
      issue(0, 0, SEL_OE,  8'h00, 8'h0F, 0);
      issue(0, 0, SEL_OUT, 8'h00, 8'hA5, 0);
      for (int c = 0; c < NUM_CH; c++) issue(1, c, SEL_PEND, 8'hFF, 8'h00, 0);
      tick(3);
      check("irq_cleared", irq, 0);

      // ch2 drive-and-readback
      tb_drv[23:20] = 4'h3;
      issue(1, 2, SEL_OUT, 8'h3C, 8'h00, 0);
      issue(1, 2, SEL_OE,  8'hFF, 8'h00, 0);
      tb_en[23:16] = 8'h00;
      tick(3);
      issue(0, 2, SEL_IN,   8'h00, 8'h3C, 0);
      issue(0, 2, SEL_PEND, 8'h00, 8'h38, 0);
      issue(1, 2, SEL_PEND, 8'h38, 8'h00, 0);

      // ch1 handed to the bench, then an external rise on pad bit 9
      tb_drv[11:8] = 4'h5;
      tb_en[11:8]  = 4'hF;
      issue(1, 1, SEL_OE, 8'h00, 8'h00, 0);
      tick(2);
      tb_drv[9] = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("irq_not_early", irq, 0);
      @(posedge clk);
      #1 check("irq_rise_bit9", irq, 1);
      issue(0, 1, SEL_PEND, 8'h00, 8'h02, 0);

      // W1C lands in the same cycle as a new rising edge: set wins
      tb_drv[9] = 1'b0;
      tick(4);
      tb_drv[9] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      issue(1, 1, SEL_PEND, 8'h02, 8'h00, 0);
      check("irq_hold_set_wins", irq, 1);
      tick(2);
      check("irq_hold_later", irq, 1);
      issue(0, 1, SEL_PEND, 8'h00, 8'h02, 0);
      issue(1, 1, SEL_PEND, 8'h02, 8'h00, 0);
      tick(3);
      check("irq_clear_ch1", irq, 0);

      // back-pressure: second request waits while the first response is held
      bus.rsp_ready = 1'b0;
      issue(0, 0, SEL_OUT, 8'h00, 8'hA5, 0);
      bus.req_write = 1'b0;
      bus.req_ch    = 3'd2;
      bus.req_sel   = SEL_OUT;
      bus.req_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("stall_req_ready", bus.req_ready, 0);
         check("stall_rsp_valid", bus.rsp_valid, 1);
         check("stall_rsp_rdata", bus.rsp_rdata, 8'hA5);
      end
      @(posedge clk);
      #1;
      q.push_back('{8'h3C, 1'b0});
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("second_rsp_valid", bus.rsp_valid, 1);
      check("second_rsp_rdata", bus.rsp_rdata, 8'h3C);

      // error requests leave state untouched
      issue(0, 4, SEL_OUT,  8'h00, 8'h00, 1);
      issue(1, 0, SEL_IN,   8'hFF, 8'h00, 1);
      issue(1, 5, SEL_OE,   8'h00, 8'h00, 1);
      issue(0, 0, SEL_OUT,  8'h00, 8'hA5, 0);
      issue(0, 0, SEL_OE,   8'h00, 8'h0F, 0);
      issue(0, 0, SEL_IN,   8'h00, 8'h35, 0);
      tick(1);
      check("scoreboard_drained", q.size(), 0);

      // reset while a response is held
      bus.rsp_ready = 1'b0;
      issue(0, 2, SEL_OUT, 8'h00, 8'h3C, 0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_rsp_valid", bus.rsp_valid, 0);
      check("rst_mid_req_ready", bus.req_ready, 1);
      check("rst_mid_pad_ch2_lo", pad[19:16], 4'h5);
      check("rst_mid_irq", irq, 0);
      q.delete();
      bus.rsp_ready = 1'b1;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
